uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Memory-mapped UART transmitter that drives the processor_uart_tx line.
//   The core writes bytes into a small FIFO, and the block serialises them as 8N1 frames.
//   It raises a level interrupt request when all queued data has been sent.
//   Pairs with the UART receive path inside the organisation unit, and its IRQ
//   feeds the interrupt control unit.
// PARAMETERS
//   CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200); legal range >= 2
//   FIFO_DEPTH    4    FIFO entries; power of two, >= 2
// PORTS
//   clock               in   1   system clock; all logic is on the rising edge
//   reset_n             in   1   synchronous reset, active-low
//   tx_data             in   8   byte to enqueue
//   tx_write            in   1   enqueue strobe, one cycle per byte
//   tx_overflow_clear   in   1   clears tx_overflow
//   tx_full             out  1   FIFO holds FIFO_DEPTH entries
//   tx_busy             out  1   a frame is in progress (state != IDLE)
//   tx_overflow         out  1   sticky: a write was dropped because the FIFO was full
//   tx_empty_irq        out  1   level IRQ: FIFO empty and state IDLE
//   uart_tx             out  1   serial line, registered, idle high
// BEHAVIOUR
//   Reset (reset_n=0 at an edge):
//     - FIFO count, pointers, bit counter and baud counter go to 0; state goes to IDLE.
//     - Outputs: uart_tx=1, tx_overflow=0, tx_full=0, tx_busy=0, tx_empty_irq=1.
//     - Reset during a frame aborts it immediately: the line returns high and queued data is discarded.
//   Write:
//     - At an edge with tx_write=1 and tx_full=0, tx_data is stored at the write pointer and count increments.
//     - tx_full is evaluated before the edge. A write while full is dropped and sets tx_overflow,
//       even if a pop occurs in the same cycle.
//     - A simultaneous push and pop leaves count unchanged.
//     - Pointers wrap modulo FIFO_DEPTH.
//   Frame:
//     - 8N1, LSB first: start bit 0, data[0..7], stop bit 1.
//     - Each bit lasts exactly CLKS_PER_BIT cycles; a frame is 10*CLKS_PER_BIT cycles.
//   FSM (registered state):
//     - IDLE:  if count>0, pop the head into the shift register, set uart_tx<=0 and go to START.
//              Otherwise uart_tx=1.
//     - START: after CLKS_PER_BIT cycles, set uart_tx<=shift[0] and go to DATA with bit_idx=0.
//     - DATA:  every CLKS_PER_BIT cycles, shift right and drive the next bit.
//              After bit 7 has completed, set uart_tx<=1 and go to STOP.
//     - STOP:  after CLKS_PER_BIT cycles, check the FIFO.
//              If count>0, pop and go straight to START (uart_tx<=0, no idle gap).
//              Otherwise go to IDLE.
//   Latency: a write into an empty FIFO at edge k pops at edge k+1; uart_tx falls after edge k+1.
//   Baud counter: counts 0..CLKS_PER_BIT-1 and is reset to 0 on every state or bit change.
//   Derived outputs:
//     - tx_empty_irq = (count==0) && (state==IDLE); it stays low during the final stop bit.
//     - tx_full = (count==FIFO_DEPTH).
//   Overflow flag:
//     - tx_overflow_clear has priority over a same-cycle set, so clear wins.
//     - The flag is otherwise held until reset.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//   1. Reset, then write 0xA5 at edge k
//      -> uart_tx falls after edge k+1; observed bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles;
//         tx_empty_irq returns to 1 at the end of the frame.
//   2. Write 0x01,0x02,0x03 back-to-back
//      -> three contiguous 40-cycle frames with no idle high between the stop and next start bits.
//   3. Write 6 bytes on consecutive cycles while the first frame starts
//      -> 5 bytes accepted (1 popped + 4 queued); tx_full=1; the 6th byte is dropped
//         and tx_overflow=1; exactly 5 frames are sent.
//   4. FIFO full, with a write in the same cycle as the STOP->START pop
//      -> write dropped, tx_overflow=1, count remains 3 after the pop.
//   5. Assert reset_n=0 in the middle of data bit 3 with 2 bytes queued
//      -> the next cycle shows uart_tx=1, tx_busy=0, tx_empty_irq=1, and no further frames.
//   6. tx_overflow_clear and a dropped write in the same cycle
//      -> tx_overflow=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small byte FIFO.
// Raises a level IRQ once every queued byte has left the line.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    input  logic       tx_overflow_clear,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic       tx_empty_irq,
    output logic       uart_tx
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [BAUD_W-1:0] baud_r, baud_s;
    logic [2:0]        bit_idx_r, bit_idx_s;
    logic [7:0]        shift_r, shift_s;
    logic              uart_tx_r, uart_tx_s;
    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic              push_s, pop_s, full_s, empty_s, bit_end_s;

    assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s   = (count_r == CNT_W'(0));
    assign bit_end_s = (baud_r == BAUD_W'(CLKS_PER_BIT - 1));
    assign push_s    = tx_write && !full_s;

    // Next-state, pop request and next line value for the frame serialiser
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        uart_tx_s = uart_tx_r;
        pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                baud_s = BAUD_W'(0);
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    shift_s   = mem_r[rd_ptr_r];
                    uart_tx_s = 1'b0;
                    state_s   = START;
                end else begin
                    uart_tx_s = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    baud_s    = BAUD_W'(0);
                    uart_tx_s = shift_r[0];
                    bit_idx_s = 3'd0;
                    state_s   = DATA;
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_s = BAUD_W'(0);
                    if (bit_idx_r == 3'd7) begin
                        uart_tx_s = 1'b1;
                        state_s   = STOP;
                    end else begin
                        shift_s   = shift_r >> 1;
                        uart_tx_s = shift_r[1];
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    baud_s = BAUD_W'(0);
                    // Back-to-back frames: go straight to START with no idle gap
                    if (!empty_s) begin
                        pop_s     = 1'b1;
                        shift_s   = mem_r[rd_ptr_r];
                        uart_tx_s = 1'b0;
                        state_s   = START;
                    end else begin
                        uart_tx_s = 1'b1;
                        state_s   = IDLE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                baud_s    = BAUD_W'(0);
                uart_tx_s = 1'b1;
                state_s   = IDLE;
            end
        endcase
    end

    // Serialiser state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            baud_r    <= BAUD_W'(0);
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            uart_tx_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            uart_tx_r <= uart_tx_s;
        end
    end

    // FIFO data storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag; a clear beats a same-cycle dropped write
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if (tx_overflow_clear) begin
            overflow_r <= 1'b0;
        end else if (tx_write && full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign tx_full      = full_s;
    assign tx_busy      = (state_r != IDLE);
    assign tx_empty_irq = empty_s && (state_r == IDLE);
    assign tx_overflow  = overflow_r;
    assign uart_tx      = uart_tx_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a line
// monitor captures every frame cycle-by-cycle and compares it against the queue.
module tb_uart_tx_fifo;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_write = 1'b0;
    logic       tx_overflow_clear = 1'b0;
    logic       tx_full, tx_busy, tx_overflow, tx_empty_irq, uart_tx;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int frames_done = 0;
    int mon_starts = 0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int starts_q[$];

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_write(tx_write),
        .tx_overflow_clear(tx_overflow_clear), .tx_full(tx_full), .tx_busy(tx_busy),
        .tx_overflow(tx_overflow), .tx_empty_irq(tx_empty_irq), .uart_tx(uart_tx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // 40 line samples per frame: start 0, data LSB first, stop 1, 4 cycles each
    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [9:0]  f;
        logic [39:0] r;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) r[i] = f[i/4];
        return r;
    endfunction

    // Line monitor: captures each frame and compares it with the scoreboard head
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (mon_en && reset_n && uart_tx === 1'b0) begin : capture
                logic [39:0] obs;
                logic [7:0]  exp_b;
                bit          aborted;
                starts_q.push_back(cyc);
                mon_starts++;
                obs = 40'd0;
                aborted = 1'b0;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clock);
                    if (!reset_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    obs[i] = uart_tx;
                end
                if (!aborted) begin
                    frames_done++;
                    check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        tests_run++;
                        if (obs !== frame_bits(exp_b)) begin
                            fails++;
                            $display("FAIL frame_bits byte %0h: got %h, expected %h",
                                     exp_b, obs, frame_bits(exp_b));
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] t3 [6];
        logic [7:0] t4 [5];
        int fsnap, ssnap;
        t3 = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        t4 = '{8'hC3, 8'h3C, 8'h81, 8'h7E, 8'hAA};

        // Reset state
        step(2);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_overflow", tx_overflow, 0);
        check("rst_full", tx_full, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_irq", tx_empty_irq, 1);
        reset_n = 1'b1;
        mon_en = 1'b1;
        step(1);

        // 1: single byte 0xA5, latency and IRQ timing
        tx_data = 8'hA5; tx_write = 1'b1; exp_q.push_back(8'hA5);
        step(1); tx_write = 1'b0;                  // after edge k
        check("t1_line_high_k", uart_tx, 1);
        check("t1_irq_low_k", tx_empty_irq, 0);
        step(1);                                   // after edge k+1
        check("t1_start_fall", uart_tx, 0);
        check("t1_busy", tx_busy, 1);
        step(39);                                  // in final stop bit
        check("t1_irq_low_stop", tx_empty_irq, 0);
        check("t1_stop_high", uart_tx, 1);
        step(1);
        check("t1_irq_end", tx_empty_irq, 1);
        check("t1_busy_end", tx_busy, 0);
        check("t1_frames", frames_done, 1);

        // 2: three back-to-back bytes, contiguous frames
        starts_q.delete();
        foreach (t3[i]) begin
            if (i < 3) begin
                tx_data = 8'h01 + 8'(i); tx_write = 1'b1; exp_q.push_back(8'h01 + 8'(i));
                step(1);
            end
        end
        tx_write = 1'b0;
        step(119);
        check("t2_irq_end", tx_empty_irq, 1);
        check("t2_starts", starts_q.size(), 3);
        if (starts_q.size() >= 3) begin
            check("t2_gap01", starts_q[1] - starts_q[0], 40);
            check("t2_gap12", starts_q[2] - starts_q[1], 40);
        end

        // 3: six writes, the sixth is dropped
        fsnap = frames_done;
        for (int i = 0; i < 6; i++) begin
            tx_data = t3[i]; tx_write = 1'b1;
            if (i < 5) exp_q.push_back(t3[i]);
            step(1);
            if (i == 4) check("t3_full", tx_full, 1);
            if (i == 4) check("t3_no_ovf_yet", tx_overflow, 0);
        end
        tx_write = 1'b0;
        check("t3_overflow", tx_overflow, 1);
        step(196);
        check("t3_irq_end", tx_empty_irq, 1);
        check("t3_frames", frames_done - fsnap, 5);
        tx_overflow_clear = 1'b1; step(1); tx_overflow_clear = 1'b0;
        check("t3_ovf_cleared", tx_overflow, 0);

        // 4: write while full in the same cycle as the STOP->START pop
        fsnap = frames_done;
        for (int i = 0; i < 5; i++) begin
            tx_data = t4[i]; tx_write = 1'b1; exp_q.push_back(t4[i]);
            step(1);
        end
        tx_write = 1'b0;                           // after edge k+4
        step(36);                                  // after edge k+40
        check("t4_full_before_pop", tx_full, 1);
        tx_data = 8'hEE; tx_write = 1'b1; step(1); tx_write = 1'b0;
        check("t4_overflow", tx_overflow, 1);
        check("t4_count3_not_full", tx_full, 0);
        tx_data = 8'h5A; tx_write = 1'b1; exp_q.push_back(8'h5A); step(1); tx_write = 1'b0;
        check("t4_full_again", tx_full, 1);
        step(199);
        check("t4_irq_end", tx_empty_irq, 1);
        check("t4_frames", frames_done - fsnap, 6);
        tx_overflow_clear = 1'b1; step(1); tx_overflow_clear = 1'b0;

        // 5: reset in the middle of data bit 3 with two bytes queued
        for (int i = 0; i < 3; i++) begin
            tx_data = (i == 0) ? 8'hF7 : 8'h99; tx_write = 1'b1;
            step(1);
        end
        tx_write = 1'b0;                           // after edge k+2
        step(16);                                  // after edge k+18, inside bit 3
        check("t5_bit3_low", uart_tx, 0);
        check("t5_busy_pre", tx_busy, 1);
        reset_n = 1'b0; step(1);
        check("t5_line_high", uart_tx, 1);
        check("t5_busy", tx_busy, 0);
        check("t5_irq", tx_empty_irq, 1);
        check("t5_full", tx_full, 0);
        step(1); reset_n = 1'b1;
        ssnap = mon_starts;
        step(100);
        check("t5_no_frames", mon_starts - ssnap, 0);
        check("t5_idle_line", uart_tx, 1);

        // 6: overflow clear beats a same-cycle dropped write
        for (int i = 0; i < 5; i++) begin
            tx_data = t3[i] ^ 8'hFF; tx_write = 1'b1; exp_q.push_back(t3[i] ^ 8'hFF);
            step(1);
        end
        tx_data = 8'h11; step(1);                  // dropped, sets flag
        check("t6_ovf_set", tx_overflow, 1);
        tx_overflow_clear = 1'b1; step(1);
        tx_overflow_clear = 1'b0; tx_write = 1'b0;
        check("t6_clear_wins", tx_overflow, 0);
        step(195);
        check("t6_irq_end", tx_empty_irq, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
